pipelined_cselect_subtractor: RTL and testbench

PIPELINED_CSELECT_SUBTRACTOR -- requirements
Module: pipelined_cselect_subtractor

---
 rtl/cselect_pkg.sv | 41 ++++
 rtl/csel_slice.sv | 58 +++++
 rtl/pipelined_cselect_subtractor.sv | 133 +++++++++++++
 tb/tb_pipelined_cselect_subtractor.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cselect_pkg.sv
// ---------------------------------------------------------------------------
// cselect_pkg
//
// Shared definitions for the pipelined carry-select subtractor.
//
// Contents:
//   CS_WIDTH     default operand width
//   CS_SLICE     default bits per carry-select slice / pipeline stage
//   NSTAGES      pipeline depth derived from the two defaults
//   stage_t      one pipeline stage register: valid flag, carry into the
//                next slice, skewed operands and the partially resolved diff
//   subOverflow  two's-complement overflow rule for a subtraction
// ---------------------------------------------------------------------------
package cselect_pkg;

  localparam int CS_WIDTH = 16;
  localparam int CS_SLICE = 4;
  localparam int NSTAGES  = CS_WIDTH / CS_SLICE;

  // One stage register.
  // a and b travel down the pipe so that later stages can still see the
  // slices they have not resolved yet. diff fills up one slice per stage,
  // lowest slice first. carry is the carry out of the most recently
  // resolved slice, i.e. the select input for the next stage's slice.
  typedef struct packed {
    logic                valid;
    logic                carry;
    logic [CS_WIDTH-1:0] a;
    logic [CS_WIDTH-1:0] b;
    logic [CS_WIDTH-1:0] diff;
  } stage_t;

  // Overflow of a - b: the operands have different signs and the result
  // sign differs from the minuend sign.
  function automatic logic subOverflow(input logic aMsb,
                                       input logic bMsb,
                                       input logic dMsb);
    return (aMsb != bMsb) && (dMsb != aMsb);
  endfunction

endpackage

// File: rtl/csel_slice.sv
// ---------------------------------------------------------------------------
// csel_slice
//
// Purely combinational SLICE-bit carry-select slice computing a + ~b + cin.
// Both carry-in cases are rippled in parallel; the incoming carry only
// drives the final mux, so the carry path through the slice is one mux.
//
// Ports:
//   i_a     minuend bits of this slice
//   i_b     subtrahend bits of this slice (inverted internally)
//   i_cin   carry into this slice (inverse of the borrow)
//   o_diff  difference bits of this slice
//   o_cout  carry out of this slice
// ---------------------------------------------------------------------------
module csel_slice
  import cselect_pkg::*;
#(
  parameter int SLICE = CS_SLICE
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_cin,
  output logic [SLICE-1:0] o_diff,
  output logic             o_cout
);

  logic [SLICE-1:0] w_bInv;
  logic [SLICE-1:0] w_sum0;
  logic [SLICE-1:0] w_sum1;
  logic             w_cout0;
  logic             w_cout1;

  // Plain ripple-carry adder; returns {carry out, sum}.
  function automatic logic [SLICE:0] ripple(input logic [SLICE-1:0] a,
                                            input logic [SLICE-1:0] b,
                                            input logic             cin);
    logic [SLICE:0] result;
    logic           carry;
    result = '0;
    carry  = cin;
    for (int i = 0; i < SLICE; i++) begin
      result[i] = a[i] ^ b[i] ^ carry;
      carry     = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    result[SLICE] = carry;
    return result;
  endfunction

  assign w_bInv = ~i_b;

  // Precompute both carry-in cases so the late-arriving carry only selects.
  assign {w_cout0, w_sum0} = ripple(i_a, w_bInv, 1'b0);
  assign {w_cout1, w_sum1} = ripple(i_a, w_bInv, 1'b1);

  assign o_diff = i_cin ? w_sum1  : w_sum0;
  assign o_cout = i_cin ? w_cout1 : w_cout0;

endmodule

// File: rtl/pipelined_cselect_subtractor.sv
// ---------------------------------------------------------------------------
// pipelined_cselect_subtractor
//
// Pipelined subtractor computing diff = A - B - Bin (mod 2^WIDTH) as
// A + ~B + ~Bin. The operand is split into N = WIDTH/SLICE carry-select
// slices and stage k of the pipeline resolves slice k, selecting on the
// carry registered by stage k-1. A result appears N rising edges after it
// is accepted (the accepting edge counts as the first).
//
// Flow control is a valid/ready handshake with one global stall: when the
// output holds a valid result that the consumer does not take, every stage
// holds. in_ready is purely a function of out_valid and out_ready.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-high reset, empties the pipeline
//   in_valid   A/B/Bin carry a valid operand set
//   in_ready   pipeline can accept an operand set this cycle
//   A, B, Bin  minuend, subtrahend, borrow in
//   out_valid  diff/Bout/ovf carry a valid result
//   out_ready  consumer takes the result this cycle
//   diff       A - B - Bin modulo 2^WIDTH
//   Bout       unsigned borrow out
//   ovf        two's-complement overflow
//
// stage_t is sized from the package defaults, so WIDTH and SLICE are
// changed by editing cselect_pkg rather than by overriding them here.
// ---------------------------------------------------------------------------
module pipelined_cselect_subtractor
  import cselect_pkg::*;
#(
  parameter int WIDTH = CS_WIDTH,
  parameter int SLICE = CS_SLICE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             Bout,
  output logic             ovf
);

  localparam int N   = NSTAGES;
  localparam int MSB = WIDTH - 1;

  stage_t           r_stage     [N];
  stage_t           w_next      [N];
  logic [SLICE-1:0] w_sliceDiff [N];
  logic             w_sliceCout [N];
  logic             w_stall;

  // One carry-select slice per stage. Stage 0 works straight from the
  // input ports with carry-in ~Bin; later stages take the skewed operand
  // bits and the carry registered by the previous stage.
  for (genvar k = 0; k < N; k++) begin : g_slice
    logic [SLICE-1:0] w_a;
    logic [SLICE-1:0] w_b;
    logic             w_cin;

    if (k == 0) begin : g_first
      assign w_a   = A[SLICE-1:0];
      assign w_b   = B[SLICE-1:0];
      assign w_cin = ~Bin;
    end else begin : g_rest
      assign w_a   = r_stage[k-1].a[k*SLICE +: SLICE];
      assign w_b   = r_stage[k-1].b[k*SLICE +: SLICE];
      assign w_cin = r_stage[k-1].carry;
    end

    csel_slice #(
      .SLICE (SLICE)
    ) u_slice (
      .i_a    (w_a),
      .i_b    (w_b),
      .i_cin  (w_cin),
      .o_diff (w_sliceDiff[k]),
      .o_cout (w_sliceCout[k])
    );
  end

  // Global stall: the only place the pipe can block is the output stage.
  assign w_stall  = r_stage[N-1].valid & ~out_ready;
  assign in_ready = ~w_stall;

  // Next contents of every stage. Stage 0 captures the new operands (its
  // valid bit is in_valid, so an idle cycle becomes a bubble); each later
  // stage inherits its predecessor and fills in its own diff slice and
  // carry. Bubbles move exactly like real entries, just with valid = 0.
  always_comb begin
    w_next[0]                   = '0;
    w_next[0].valid             = in_valid;
    w_next[0].carry             = w_sliceCout[0];
    w_next[0].a                 = A;
    w_next[0].b                 = B;
    w_next[0].diff[SLICE-1:0]   = w_sliceDiff[0];
    for (int k = 1; k < N; k++) begin
      w_next[k]                         = r_stage[k-1];
      w_next[k].carry                   = w_sliceCout[k];
      w_next[k].diff[k*SLICE +: SLICE]  = w_sliceDiff[k];
    end
  end

  // Stage registers: cleared by reset, frozen as a whole during a stall,
  // otherwise every stage advances by one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        r_stage[k] <= '0;
      end
    end else if (!w_stall) begin
      for (int k = 0; k < N; k++) begin
        r_stage[k] <= w_next[k];
      end
    end
  end

  // Outputs come only from the last stage register. The raw carry of an
  // empty stage is 0, which would read as a borrow, so Bout is qualified
  // with the valid bit to keep it low after reset.
  assign out_valid = r_stage[N-1].valid;
  assign diff      = r_stage[N-1].diff;
  assign Bout      = r_stage[N-1].valid & ~r_stage[N-1].carry;
  assign ovf       = subOverflow(r_stage[N-1].a[MSB],
                                 r_stage[N-1].b[MSB],
                                 r_stage[N-1].diff[MSB]);

endmodule

// File: tb/tb_pipelined_cselect_subtractor.sv
// ---------------------------------------------------------------------------
// tb_pipelined_cselect_subtractor
//
// Directed and randomised checks of the pipelined carry-select subtractor:
// reset state, latency and hand-computed results, a mid-stream stall,
// reset with entries in flight, and a long random stream against a
// behavioural reference model.
// ---------------------------------------------------------------------------
module tb_pipelined_cselect_subtractor;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        Bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        Bout;
  logic        ovf;

  int          assertCount = 0;
  int          failCount   = 0;
  int          resultCount = 0;
  logic [17:0] expQ[$];
  logic        lastAccepted;
  logic        lastInReady;

  logic [15:0] stA [8] = '{16'h0001, 16'h1234, 16'h8000, 16'h7FFF,
                           16'hFFFF, 16'h0F0F, 16'hA5A5, 16'h0000};
  logic [15:0] stB [8] = '{16'h0002, 16'h0034, 16'h0001, 16'hFFFF,
                           16'hFFFF, 16'h00F0, 16'h5A5A, 16'h0000};
  logic [7:0]  stBin   = 8'b1001_0100;

  always #5 clk = ~clk;

  pipelined_cselect_subtractor #(
    .WIDTH (16),
    .SLICE (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .Bout      (Bout),
    .ovf       (ovf)
  );

  // Reference model: unsigned 17-bit subtraction for diff/borrow and
  // signed integer range check for overflow. Returns {diff, Bout, ovf}.
  function automatic logic [17:0] refSub(input logic [15:0] a,
                                         input logic [15:0] b,
                                         input logic        bin);
    logic [16:0] wide;
    int          sa;
    int          sb;
    int          sd;
    logic        o;
    wide = {1'b0, a} - {1'b0, b} - {16'b0, bin};
    sa   = $signed(a);
    sb   = $signed(b);
    sd   = sa - sb - int'(bin);
    o    = (sd > 32767) || (sd < -32768);
    return {wide[15:0], wide[16], o};
  endfunction

  task automatic checkOutput(input string       tag,
                             input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
      else begin
        failCount++;
        $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
  endtask

  // Drive one cycle's inputs at posedge+1, sample the handshake at the
  // negedge (score outputs consumed, queue accepted operands), then move
  // to just after the next rising edge.
  task automatic applyStimulus(input logic        iv,
                               input logic [15:0] a,
                               input logic [15:0] b,
                               input logic        bin,
                               input logic        ordy);
    logic [17:0] e;
    in_valid  = iv;
    A         = a;
    B         = b;
    Bin       = bin;
    out_ready = ordy;
    @(negedge clk);
    lastInReady  = in_ready;
    lastAccepted = iv && in_ready;
    if (out_valid && out_ready) begin
      checkOutput("result_expected", expQ.size() != 0, 1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        resultCount++;
        checkOutput("stream_diff", diff, e[17:2]);
        checkOutput("stream_bout", Bout, e[1]);
        checkOutput("stream_ovf",  ovf,  e[0]);
      end
    end
    if (lastAccepted) expQ.push_back(refSub(a, b, bin));
    @(posedge clk);
    #1;
  endtask

  // Single isolated transaction with hand-computed expectations: accepted
  // on the first edge, visible exactly on the fourth, gone after the fifth.
  task automatic latencyCheck(input string       tag,
                              input logic [15:0] a,
                              input logic [15:0] b,
                              input logic        bin,
                              input logic [15:0] expDiff,
                              input logic        expBout,
                              input logic        expOvf);
    in_valid  = 1'b1;
    A         = a;
    B         = b;
    Bin       = bin;
    out_ready = 1'b1;
    #1;
    checkOutput({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A        = 16'hDEAD;
    B        = 16'hBEEF;
    Bin      = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      checkOutput({tag, "_out_valid"}, out_valid, (e == 4));
      if (e < 4) begin
        @(posedge clk);
        #1;
      end
    end
    checkOutput({tag, "_diff"}, diff, expDiff);
    checkOutput({tag, "_bout"}, Bout, expBout);
    checkOutput({tag, "_ovf"},  ovf,  expOvf);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput({tag, "_drained"}, out_valid, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          idx;
    int          base;
    int          sent;
    int          cycles;
    logic        ordy;
    logic        iv;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rbin;
    logic [18:0] snap;

    // Reset state, with out_ready low to show in_ready does not need it.
    reset     = 1'b1;
    in_valid  = 1'b0;
    A         = 16'h0;
    B         = 16'h0;
    Bin       = 1'b0;
    out_ready = 1'b0;
    #3;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_in_ready",  in_ready,  1);
    checkOutput("reset_diff",      diff,      0);
    checkOutput("reset_bout",      Bout,      0);
    checkOutput("reset_ovf",       ovf,       0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed vectors, expected values worked out by hand.
    latencyCheck("basic",     16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    latencyCheck("underflow", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    latencyCheck("bin_eq",    16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    latencyCheck("neg_ovf",   16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    latencyCheck("pos_ovf",   16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    latencyCheck("bin_ovf",   16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b1);
    latencyCheck("ripple",    16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0);
    latencyCheck("zero",      16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0);
    latencyCheck("mixed",     16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0);

    // Back-to-back stream of 8 with out_ready low in cycles 6..8.
    idx  = 0;
    base = resultCount;
    snap = '0;
    for (int c = 0; c < 24; c++) begin
      if (c == 6) snap = {out_valid, diff, Bout, ovf};
      if (c >= 7 && c <= 9) checkOutput("stall_stable", {out_valid, diff, Bout, ovf}, snap);
      ordy = !(c >= 6 && c <= 8);
      applyStimulus(idx < 8,
                    (idx < 8) ? stA[idx] : 16'h0,
                    (idx < 8) ? stB[idx] : 16'h0,
                    (idx < 8) ? stBin[idx] : 1'b0,
                    ordy);
      if (c >= 6 && c <= 8) checkOutput("stall_in_ready", lastInReady, 0);
      if (lastAccepted) idx++;
    end
    checkOutput("stall_snap_valid", snap[18], 1);
    checkOutput("stall_sent",       idx, 8);
    checkOutput("stall_results",    resultCount - base, 8);
    checkOutput("stall_queue",      expQ.size(), 0);

    // Reset with three entries in flight, the oldest already at the output.
    applyStimulus(1'b1, 16'h1111, 16'h0101, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'h2222, 16'h0202, 1'b1, 1'b1);
    applyStimulus(1'b1, 16'h3333, 16'h0303, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #1;
    checkOutput("pre_reset_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_in_ready",  in_ready,  1);
    checkOutput("midreset_diff",      diff,      0);
    checkOutput("midreset_bout",      Bout,      0);
    expQ.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("held_reset_valid", out_valid, 0);
    reset = 1'b0;
    latencyCheck("post_reset", 16'h00FF, 16'h0F0F, 1'b0, 16'hF1F0, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("no_stale", out_valid, 0);
      @(posedge clk);
      #1;
    end

    // Random stream with random in_valid and out_ready.
    base   = resultCount;
    sent   = 0;
    cycles = 0;
    while (sent < 10000 && cycles < 60000) begin
      iv   = ($urandom_range(3) != 0);
      ordy = ($urandom_range(3) != 0);
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom_range(1));
      applyStimulus(iv, ra, rb, rbin, ordy);
      if (lastAccepted) sent++;
      cycles++;
    end
    checkOutput("random_sent", sent, 10000);
    for (int d = 0; d < 20 && expQ.size() != 0; d++) begin
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    end
    checkOutput("random_drain",   expQ.size(), 0);
    checkOutput("random_results", resultCount - base, 10000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
